// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common data bus arbiter. Grants at most one functional-unit
// result per cycle using rotating round-robin priority and broadcasts the
// winner on a registered CDB one cycle later. Losing FUs are back-pressured
// through fu_ready. A flush kills the pending broadcast and blocks grants.
//
// Optional feature (compile-time macro CDB_STALL_CNT_EN): adds a 16-bit
// saturating counter, cdb_stall_cnt. It counts the cycles in which at least
// one requesting FU was left without a grant.
module cdb_arbiter #(
  parameter  int NUM_FUS     = 4,
  parameter  int ROB_ENTRIES = 32,
  parameter  int NUM_PREGS   = 64,
  parameter  int XLEN        = 32,
  localparam int PTR_W       = $clog2(NUM_FUS),
  localparam int ROB_W       = $clog2(ROB_ENTRIES),
  localparam int PREG_W      = $clog2(NUM_PREGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_FUS-1:0]        fu_valid,
  output logic [NUM_FUS-1:0]        fu_ready,
  input  logic [NUM_FUS*ROB_W-1:0]  fu_rob_idx,
  input  logic [NUM_FUS*PREG_W-1:0] fu_dst_preg,
  input  logic [NUM_FUS-1:0]        fu_wr_en,
  input  logic [NUM_FUS*XLEN-1:0]   fu_data,
  input  logic [NUM_FUS-1:0]        fu_br_taken,
  output logic                      cdb_valid,
  output logic [ROB_W-1:0]          cdb_rob_idx,
  output logic [PREG_W-1:0]         cdb_dst_preg,
  output logic                      cdb_wr_en,
  output logic [XLEN-1:0]           cdb_data,
  output logic                      cdb_br_taken
`ifdef CDB_STALL_CNT_EN
  ,
  output logic [15:0]               cdb_stall_cnt
`endif
);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   nxt_ptr;
  logic [NUM_FUS-1:0] gnt;
  logic               gnt_any;
  logic [PTR_W-1:0]   gnt_idx;

  logic [ROB_W-1:0]   rob_sel;
  logic [PREG_W-1:0]  preg_sel;
  logic [XLEN-1:0]    data_sel;
  logic               wr_sel;
  logic               br_sel;

  logic               vld_p1;
  logic [ROB_W-1:0]   rob_p1;
  logic [PREG_W-1:0]  preg_p1;
  logic [XLEN-1:0]    data_p1;
  logic               wr_p1;
  logic               br_p1;

  // Round-robin scan starting at rr_ptr; flush or reset suppresses any grant.
  always_comb begin : grant_scan
    int               idx;
    logic [PTR_W-1:0] sel;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < NUM_FUS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_FUS) idx = idx - NUM_FUS;
      sel = idx[PTR_W-1:0];
      if (!gnt_any && fu_valid[sel]) begin
        gnt_any  = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
    if (flush || !rst) begin
      gnt     = '0;
      gnt_any = 1'b0;
    end
  end

  assign fu_ready = gnt;
  assign nxt_ptr  = (gnt_idx == PTR_W'(NUM_FUS - 1)) ? '0 : gnt_idx + 1'b1;

  // One-hot mux of the granted FU's result fields.
  always_comb begin
    rob_sel  = '0;
    preg_sel = '0;
    data_sel = '0;
    wr_sel   = 1'b0;
    br_sel   = 1'b0;
    for (int i = 0; i < NUM_FUS; i++) begin
      if (gnt[i]) begin
        rob_sel  = fu_rob_idx[i*ROB_W +: ROB_W];
        preg_sel = fu_dst_preg[i*PREG_W +: PREG_W];
        data_sel = fu_data[i*XLEN +: XLEN];
        wr_sel   = fu_wr_en[i];
        br_sel   = fu_br_taken[i];
      end
    end
  end

  // Priority pointer advances past the winner; holds when nothing is granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= nxt_ptr;
    end
  end

  // CDB broadcast register: capture the winner, clear on flush or idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      rob_p1  <= '0;
      preg_p1 <= '0;
      data_p1 <= '0;
      wr_p1   <= 1'b0;
      br_p1   <= 1'b0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      rob_p1  <= '0;
      preg_p1 <= '0;
      data_p1 <= '0;
      wr_p1   <= 1'b0;
      br_p1   <= 1'b0;
    end else if (gnt_any) begin
      vld_p1  <= 1'b1;
      rob_p1  <= rob_sel;
      preg_p1 <= preg_sel;
      data_p1 <= data_sel;
      wr_p1   <= wr_sel;
      br_p1   <= br_sel;
    end else begin
      vld_p1  <= 1'b0;
      wr_p1   <= 1'b0;
      br_p1   <= 1'b0;
    end
  end

  assign cdb_valid    = vld_p1;
  assign cdb_rob_idx  = rob_p1;
  assign cdb_dst_preg = preg_p1;
  assign cdb_data     = data_p1;
  assign cdb_wr_en    = wr_p1;
  assign cdb_br_taken = br_p1;

`ifdef CDB_STALL_CNT_EN
  logic [15:0] stall_cnt;

  // Count cycles with an unserved requester (flush cycles included); saturate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (|(fu_valid & ~gnt) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign cdb_stall_cnt = stall_cnt;
`endif

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common data bus (CDB) arbiter between the functional units and the writeback/wakeup consumers: ROB, physical register file and the dispatch/scheduler reservation stations. Each cycle it grants at most one FU result with a rotating round-robin priority and drives a registered CDB broadcast the next cycle. It back-pressures losing FUs through per-FU ready signals and supports a pipeline flush.

## Interface
- NUM_FUS, 4, number of requesting functional units (≥2)
- ROB_ENTRIES, 32, ROB depth; rob index width is $clog2(ROB_ENTRIES)
- NUM_PREGS, 64, physical registers; preg width is $clog2(NUM_PREGS)
- XLEN, 32, result data width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- flush  input  1  pipeline flush; kills pending broadcast and blocks grants
- fu_valid  input  NUM_FUS  result request per FU
- fu_ready  output  NUM_FUS  one-hot-or-zero grant; transfer when fu_valid[i] & fu_ready[i]
- fu_rob_idx  input  NUM_FUS×$clog2(ROB_ENTRIES)  packed ROB index per FU
- fu_dst_preg  input  NUM_FUS×$clog2(NUM_PREGS)  packed destination preg per FU
- fu_wr_en  input  NUM_FUS  result writes a register
- fu_data  input  NUM_FUS×XLEN  packed result data per FU
- fu_br_taken  input  NUM_FUS  resolved branch outcome per FU
- cdb_valid  output  1  broadcast valid
- cdb_rob_idx  output  $clog2(ROB_ENTRIES)  broadcast ROB index
- cdb_dst_preg  output  $clog2(NUM_PREGS)  broadcast preg (wakeup tag)
- cdb_wr_en  output  1  regfile write enable (= cdb_valid & granted fu_wr_en)
- cdb_data  output  XLEN  broadcast data
- cdb_br_taken  output  1  broadcast branch outcome

## Operation
- State: rr_ptr ($clog2(NUM_FUS) bits), registered CDB output fields.
- Grant (combinational): scan FUs from rr_ptr upward, wrapping modulo NUM_FUS; first i with fu_valid[i]=1 gets fu_ready[i]=1. All others 0.
- No requester or flush=1 → fu_ready=0.
- On a grant to i, rr_ptr ← (i+1) mod NUM_FUS. No grant → rr_ptr holds.
- fu_ready never depends on cdb output state; the CDB is never stalled by consumers.
- Granted FU fields are captured into the output registers. cdb_wr_en = fu_wr_en[i], and is 0 whenever cdb_valid=0.
- Loser FUs hold fu_valid and their fields stable until granted. The arbiter keeps no per-FU buffering.
- Flush: the output registers are cleared (cdb_valid=0, cdb_wr_en=0) at the next edge, and there is no grant in the flush cycle. rr_ptr is unchanged.
- Pointer wrap: rr_ptr = NUM_FUS-1 granting FU NUM_FUS-1 → rr_ptr=0.

## Timing
- Reset (rst=0, asynchronous): rr_ptr=0, cdb_valid=0, cdb_wr_en=0, cdb_br_taken=0, cdb_rob_idx=0, cdb_dst_preg=0, cdb_data=0. fu_ready=0 while rst=0.
- Latency: grant in cycle N (combinational), broadcast valid in cycle N+1 for exactly one cycle unless re-granted.
- Throughput: one result per cycle. Back-to-back grants produce a continuous cdb_valid.
- Fairness: a continuously requesting FU is granted within NUM_FUS cycles.
- Reset deasserted mid-cycle: first grant occurs at the first rising edge after release, with priority starting at FU0.
- Simultaneous flush and fu_valid: flush wins; no transfer happens, and the FU must retry.

## Configuration
- CDB_STALL_CNT_EN defined: adds output port cdb_stall_cnt (16 bits).
  - Increments each cycle in which at least one fu_valid is set but not granted, flush cycles included.
  - Saturates at 0xFFFF; cleared by reset only.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Test plan
- Reset, then FU1 requests alone (rob 5, preg 33, data 0x10, wr_en 1) → fu_ready=4'b0010 same cycle; next cycle cdb_valid=1, rob 5, preg 33, data 0x10, cdb_wr_en=1; rr_ptr=2.
- All four FUs request continuously from reset → grant order FU0,1,2,3,0 over 5 cycles; cdb_valid high each following cycle; no FU waits >4 cycles.
- rr_ptr=3 with FU3 and FU0 requesting → FU3 granted, then FU0 (wrap); rr_ptr ends at 1.
- Branch result from FU2 with wr_en 0, br_taken 1 → cdb_valid=1, cdb_wr_en=0, cdb_br_taken=1.
- flush=1 while FU0 and FU2 request, with cdb_valid=1 → fu_ready=0, cdb_valid=0 next cycle, rr_ptr unchanged; grants resume the cycle after flush drops.
- With CDB_STALL_CNT_EN: 3 FUs request for 10 cycles → cdb_stall_cnt=10. Assert rst=0 mid-burst → all outputs zero immediately, counter 0.
